uart_dbg_ctrl: RTL and testbench
================================

# uart_dbg_ctrl

UART debug command controller: parses a byte stream from the SoC UART receiver into read, write and execute commands and sequences them as single-outstanding OBI master transactions on the main crossbar. Replies go back as a byte stream to the UART transmitter. It gives host-side loading and boot control without JTAG, as an alternative to the debug module's system-bus access for SRAM preload and boot.

## Interface
- `BootAddrAddr`, default `32'h0300_0004`: SoC-control boot-address register, written by EXEC.
- `FetchEnAddr`, default `32'h0300_0008`: SoC-control fetch-enable register, written by EXEC.
- `TimeoutCycles`, default `1_000_000`: inter-byte timeout; used only when the timeout is compiled in.
- `clk_i` in 1: system clock. One clock domain.
- `rst_i` in 1: reset, synchronous, active-high.
- `rx_data_i` in 8: received byte.
- `rx_valid_i` in 1: received byte valid.
- `rx_ready_o` out 1: controller accepts the byte.
- `tx_data_o` out 8: reply byte.
- `tx_valid_o` out 1: reply byte valid.
- `tx_ready_i` in 1: transmitter accepts the byte.
- OBI master ports:
  - `obi_req_o` out 1, `obi_gnt_i` in 1.
  - `obi_addr_o` out 32, `obi_we_o` out 1, `obi_be_o` out 4, `obi_wdata_o` out 32.
  - `obi_rvalid_i` in 1, `obi_rdata_i` in 32, `obi_err_i` in 1.
- `busy_o` out 1: high whenever the controller is not in IDLE.

## Operation
- All multi-byte fields are little-endian.
- Command bytes:
  - READ 0x11
  - WRITE 0x12
  - EXEC 0x13
- Reply bytes:
  - ACK 0x06
  - EOT 0x04
  - NAK 0x15
- In IDLE, any byte other than 0x11, 0x12 or 0x13 is consumed and dropped. No reply is sent.
- READ frame: cmd, addr[4], n[1]. The controller transfers n+1 words (1..256).
  - Reply is ACK, then each word as 4 bytes, then EOT.
- WRITE frame: cmd, addr[4], n[1], then (n+1)×4 data bytes.
  - Each word is written to the bus as soon as its 4 bytes have been assembled.
  - Reply is ACK after the last write's rvalid.
- EXEC frame: cmd, addr[4].
  - The controller writes addr to BootAddrAddr, then 32'h1 to FetchEnAddr.
  - Reply is ACK.
- Addresses: addr[1:0] is forced to 0. The address increments by 4 per word and wraps modulo 2^32. `obi_be_o` is always 4'hF.
- FSM states:
  - IDLE → HDR_ADDR (4 bytes) → HDR_LEN (READ/WRITE only)
  - READ path: TX_ACK → {BUS_REQ → BUS_RSP → TX_DATA(4 bytes)}×(n+1) → TX_EOT → IDLE.
  - WRITE path: {RX_DATA(4 bytes) → BUS_REQ → BUS_RSP}×(n+1) → TX_ACK → IDLE.
  - EXEC path: BUS_REQ(boot) → BUS_RSP → BUS_REQ(fetch) → BUS_RSP → TX_ACK → IDLE.
- Bus error (`obi_err_i` with rvalid):
  - READ: the remaining words and the EOT are suppressed; NAK is sent, then IDLE.
  - WRITE: all remaining data bytes are still consumed, but their bus writes are suppressed. The final reply is NAK instead of ACK.
  - EXEC: on a boot-write error, the fetch write is skipped and NAK is sent.
- `rx_ready_o` is high only in IDLE, HDR_ADDR, HDR_LEN and RX_DATA. A byte transfers when valid and ready are both high.

## Timing
- While `rst_i` is high, every output is 0, all counters are 0 and the FSM is in IDLE.
  - Reset asserted mid-command aborts the command. No reply is sent, and any pending OBI request is dropped.
- `rx_ready_o` is registered. It is 1 in the first cycle after reset deassertion.
- `obi_req_o` rises in the cycle after BUS_REQ is entered. It stays high with `obi_addr_o`, `obi_we_o` and `obi_wdata_o` stable until the cycle in which `obi_gnt_i` is high (inclusive).
- Only one transaction is outstanding at a time. `obi_rvalid_i` arrives at the earliest one cycle after the grant. No new request is issued before the response.
- `tx_valid_o` and `tx_data_o` are held stable until `tx_ready_i`. After each accepted byte, the next byte is presented in the following cycle.
- Word counter: 8 bits, counting n down to 0. Wrap to 0xFF does not occur; the final word is detected at count 0.
- Latency: for a READ word, the first data byte is valid 1 cycle after the rvalid cycle. Assuming same-cycle grant, the first OBI request of a WRITE or EXEC word is raised 1 cycle after its last header/data byte transfers.

## Configuration
- `UART_DBG_TIMEOUT_EN` defined: a 32-bit counter reloads on every RX transfer while the FSM is in HDR_ADDR, HDR_LEN or RX_DATA.
  - If it reaches TimeoutCycles, the command is abandoned and NAK is sent. Any in-progress WRITE stops; words already written remain written.
  - The counter is inactive in all other states.
- Undefined: no timeout logic exists, and a partial frame waits indefinitely.

## Structure
- `uart_dbg_pkg` holds:
  - command and reply byte localparams;
  - the FSM state enum;
  - a `cmd_e` enum {READ, WRITE, EXEC}.
- Sub-module `uart_dbg_shift` is a 4-byte little-endian assembler/serializer with a byte index counter. The FSM uses it for the header address, write data and read data.

## Test plan
- READ 0x11 00 00 00 10 00, slave returns 0xDEADBEEF at 0x1000_0000 → TX is 06 EF BE AD DE 04, with exactly one OBI read at 0x1000_0000.
- WRITE 0x12 04 00 00 10 01 + 8 bytes 11 22 33 44 55 66 77 88:
  - OBI writes 0x44332211 @0x1000_0004, then 0x88776655 @0x1000_0008.
  - TX is 06 after the second rvalid.
- EXEC 0x13 80 00 00 10:
  - OBI writes 0x1000_0080 @BootAddrAddr, then 0x1 @FetchEnAddr.
  - TX is 06.
- READ with n=1 and `obi_err_i` on the first response → TX is 06 15, with no second bus request.
- Stray bytes 0x00 0xFF in IDLE, then a valid READ → no reply to the strays, and a normal reply to the READ.
- Reset pulsed mid-WRITE after 2 data bytes, then a fresh READ → no TX during or after reset until the READ, and the READ completes normally.

Source files
------------

// File: rtl/uart_dbg_pkg.sv
// -----------------------------------------------------------------------------
// uart_dbg_pkg
// Shared definitions for the UART debug command controller:
//   - command / reply byte codes
//   - FSM state enum and command enum
//   - small decode helpers used by the controller
// Optional feature macro used elsewhere in this slice: UART_DBG_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package uart_dbg_pkg;

    localparam logic [7:0] CMD_READ  = 8'h11;
    localparam logic [7:0] CMD_WRITE = 8'h12;
    localparam logic [7:0] CMD_EXEC  = 8'h13;

    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_EOT   = 8'h04;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_ADDR,
        ST_HDR_LEN,
        ST_RX_DATA,
        ST_BUS_REQ,
        ST_BUS_RSP,
        ST_TX_ACK,
        ST_TX_DATA,
        ST_TX_EOT,
        ST_TX_NAK
    } state_e;

    typedef enum logic [1:0] {
        READ,
        WRITE,
        EXEC
    } cmd_e;

    function automatic logic is_cmd_byte(input logic [7:0] b);
        return (b == CMD_READ) || (b == CMD_WRITE) || (b == CMD_EXEC);
    endfunction

    function automatic cmd_e to_cmd(input logic [7:0] b);
        if (b == CMD_WRITE)     return WRITE;
        else if (b == CMD_EXEC) return EXEC;
        else                    return READ;
    endfunction

    // States in which the controller accepts RX bytes.
    function automatic logic is_rx_state(input state_e s);
        return (s == ST_IDLE) || (s == ST_HDR_ADDR) ||
               (s == ST_HDR_LEN) || (s == ST_RX_DATA);
    endfunction

    // States covered by the inter-byte timeout (a frame is in progress).
    function automatic logic is_frame_state(input state_e s);
        return (s == ST_HDR_ADDR) || (s == ST_HDR_LEN) || (s == ST_RX_DATA);
    endfunction

endpackage

// File: rtl/uart_dbg_shift.sv
// -----------------------------------------------------------------------------
// uart_dbg_shift
// 4-byte little-endian assembler / serializer with a byte index counter.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_clr            : return byte index to 0
//   i_load, i_load_word : load a full word for serializing (index -> 0)
//   i_push, i_byte   : write i_byte into lane [index], index++
//   i_pop            : advance index after o_byte was consumed
//   o_word           : assembled word
//   o_byte           : byte at the current index
//   o_last           : current index is the last (byte 3)
// -----------------------------------------------------------------------------
module uart_dbg_shift
    import uart_dbg_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [31:0] i_load_word,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    input  logic        i_pop,
    output logic [31:0] o_word,
    output logic [7:0]  o_byte,
    output logic        o_last
);

    logic [31:0] r_word;
    logic [1:0]  r_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_clr) begin
            r_idx  <= '0;
        end else if (i_load) begin
            r_word <= i_load_word;
            r_idx  <= '0;
        end else if (i_push) begin
            r_word[{r_idx, 3'b000} +: 8] <= i_byte;
            r_idx  <= r_idx + 2'd1;
        end else if (i_pop) begin
            r_idx  <= r_idx + 2'd1;
        end
    end

    assign o_word = r_word;
    assign o_byte = r_word[{r_idx, 3'b000} +: 8];
    assign o_last = (r_idx == 2'd3);

endmodule

// File: rtl/uart_dbg_ctrl.sv
// -----------------------------------------------------------------------------
// uart_dbg_ctrl
// UART debug command controller. Parses READ (0x11) / WRITE (0x12) /
// EXEC (0x13) frames from the UART RX byte stream, runs them as
// single-outstanding OBI master transactions and streams replies to UART TX.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   rx_data_i/valid_i/ready_o: byte stream from the UART receiver
//   tx_data_o/valid_o/ready_i: reply stream to the UART transmitter
//   obi_*                    : OBI master (req/gnt, addr/we/be/wdata, rvalid/rdata/err)
//   busy_o                   : controller not idle
// Optional feature: define UART_DBG_TIMEOUT_EN to abandon a partial frame
// with NAK after TimeoutCycles cycles without an RX byte.
// -----------------------------------------------------------------------------
module uart_dbg_ctrl
    import uart_dbg_pkg::*;
#(
    parameter logic [31:0] BootAddrAddr  = 32'h0300_0004,
    parameter logic [31:0] FetchEnAddr   = 32'h0300_0008,
    parameter int unsigned TimeoutCycles = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i,
    output logic        busy_o
);

    state_e      r_state;
    state_e      w_state_nxt;
    cmd_e        r_cmd;
    logic        r_rx_ready;
    logic [31:0] r_addr;
    logic [7:0]  r_cnt;
    logic        r_err;     // a bus error was seen in this command
    logic        r_fetch;   // EXEC: second (fetch-enable) write pending

    logic        w_run;
    logic        w_rx_fire;
    logic        w_tx_fire;
    logic        w_gnt;
    logic        w_tx_valid;
    logic [7:0]  w_tx_data;
    logic [31:0] w_bus_addr;
    logic [31:0] w_bus_wdata;
    logic        w_tmo;

    logic        w_sh_clr, w_sh_load, w_sh_push, w_sh_pop, w_sh_last;
    logic [31:0] w_sh_word;
    logic [7:0]  w_sh_byte;

    // Outputs are forced to 0 while reset is asserted, including the cycle
    // in which reset first rises and the state register still holds the
    // pre-reset state.
    assign w_run      = ~rst_i;
    assign rx_ready_o = r_rx_ready & w_run;
    assign w_rx_fire  = rx_valid_i & rx_ready_o;
    assign w_tx_fire  = tx_valid_o & tx_ready_i;
    assign w_gnt      = obi_req_o & obi_gnt_i;

    uart_dbg_shift u_shift (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_clr       (w_sh_clr),
        .i_load      (w_sh_load),
        .i_load_word (obi_rdata_i),
        .i_push      (w_sh_push),
        .i_byte      (rx_data_i),
        .i_pop       (w_sh_pop),
        .o_word      (w_sh_word),
        .o_byte      (w_sh_byte),
        .o_last      (w_sh_last)
    );

    assign w_sh_clr  = (r_state == ST_IDLE);
    assign w_sh_push = w_rx_fire & ((r_state == ST_HDR_ADDR) | (r_state == ST_RX_DATA));
    assign w_sh_load = (r_state == ST_BUS_RSP) & obi_rvalid_i & ~obi_err_i & (r_cmd == READ);
    assign w_sh_pop  = w_tx_fire & (r_state == ST_TX_DATA);

`ifdef UART_DBG_TIMEOUT_EN
    logic [31:0] r_tmo;

    // Counts idle cycles since the last RX byte of the frame in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                   r_tmo <= '0;
        else if (!is_frame_state(r_state) || w_rx_fire) r_tmo <= '0;
        else                                         r_tmo <= r_tmo + 32'd1;
    end

    assign w_tmo = is_frame_state(r_state) & ~w_rx_fire & (r_tmo >= TimeoutCycles);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TimeoutCycles;
    assign w_tmo        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:
                if (w_rx_fire && is_cmd_byte(rx_data_i)) w_state_nxt = ST_HDR_ADDR;
            ST_HDR_ADDR:
                if (w_rx_fire && w_sh_last)
                    w_state_nxt = (r_cmd == EXEC) ? ST_BUS_REQ : ST_HDR_LEN;
            ST_HDR_LEN:
                if (w_rx_fire)
                    w_state_nxt = (r_cmd == READ) ? ST_TX_ACK : ST_RX_DATA;
            ST_RX_DATA:
                // After a write error the remaining words are drained without bus access.
                if (w_rx_fire && w_sh_last) begin
                    if (!r_err)            w_state_nxt = ST_BUS_REQ;
                    else if (r_cnt == 8'd0) w_state_nxt = ST_TX_NAK;
                end
            ST_BUS_REQ:
                if (w_gnt) w_state_nxt = ST_BUS_RSP;
            ST_BUS_RSP:
                if (obi_rvalid_i) begin
                    case (r_cmd)
                        READ:  w_state_nxt = obi_err_i ? ST_TX_NAK : ST_TX_DATA;
                        WRITE: begin
                            if (r_cnt != 8'd0)         w_state_nxt = ST_RX_DATA;
                            else if (r_err || obi_err_i) w_state_nxt = ST_TX_NAK;
                            else                       w_state_nxt = ST_TX_ACK;
                        end
                        default: begin
                            if (obi_err_i)     w_state_nxt = ST_TX_NAK;
                            else if (!r_fetch) w_state_nxt = ST_BUS_REQ;
                            else               w_state_nxt = ST_TX_ACK;
                        end
                    endcase
                end
            ST_TX_ACK:
                if (w_tx_fire) w_state_nxt = (r_cmd == READ) ? ST_BUS_REQ : ST_IDLE;
            ST_TX_DATA:
                if (w_tx_fire && w_sh_last)
                    w_state_nxt = (r_cnt == 8'd0) ? ST_TX_EOT : ST_BUS_REQ;
            ST_TX_EOT, ST_TX_NAK:
                if (w_tx_fire) w_state_nxt = ST_IDLE;
            default:
                w_state_nxt = ST_IDLE;
        endcase
        if (w_tmo) w_state_nxt = ST_TX_NAK;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b1;
            r_cmd      <= READ;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_fetch    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rx_ready <= is_rx_state(w_state_nxt);
            case (r_state)
                ST_IDLE:
                    if (w_rx_fire && is_cmd_byte(rx_data_i)) begin
                        r_cmd   <= to_cmd(rx_data_i);
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_fetch <= 1'b0;
                    end
                ST_HDR_ADDR:
                    // Top byte arrives this cycle; the low two bits are dropped.
                    if (w_rx_fire && w_sh_last)
                        r_addr <= {rx_data_i, w_sh_word[23:2], 2'b00};
                ST_HDR_LEN:
                    if (w_rx_fire) r_cnt <= rx_data_i;
                ST_RX_DATA:
                    if (w_rx_fire && w_sh_last && r_err && r_cnt != 8'd0) begin
                        r_cnt  <= r_cnt - 8'd1;
                        r_addr <= r_addr + 32'd4;
                    end
                ST_BUS_RSP:
                    if (obi_rvalid_i) begin
                        if (obi_err_i) r_err <= 1'b1;
                        if (r_cmd == WRITE && r_cnt != 8'd0) begin
                            r_cnt  <= r_cnt - 8'd1;
                            r_addr <= r_addr + 32'd4;
                        end
                        if (r_cmd == EXEC) r_fetch <= 1'b1;
                    end
                ST_TX_DATA:
                    if (w_tx_fire && w_sh_last && r_cnt != 8'd0) begin
                        r_cnt  <= r_cnt - 8'd1;
                        r_addr <= r_addr + 32'd4;
                    end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_tx_valid = 1'b1;
        w_tx_data  = 8'h00;
        case (r_state)
            ST_TX_ACK:  w_tx_data = RSP_ACK;
            ST_TX_EOT:  w_tx_data = RSP_EOT;
            ST_TX_NAK:  w_tx_data = RSP_NAK;
            ST_TX_DATA: w_tx_data = w_sh_byte;
            default:    w_tx_valid = 1'b0;
        endcase
    end

    // Bus fields derive from registers only, so they stay stable while
    // the request waits for a grant.
    always_comb begin
        w_bus_addr  = r_addr;
        w_bus_wdata = '0;
        case (r_cmd)
            WRITE: w_bus_wdata = w_sh_word;
            EXEC: begin
                w_bus_addr  = r_fetch ? FetchEnAddr : BootAddrAddr;
                w_bus_wdata = r_fetch ? 32'h1 : r_addr;
            end
            default: ;
        endcase
    end

    assign tx_valid_o  = w_tx_valid & w_run;
    assign tx_data_o   = w_run ? w_tx_data : 8'h00;
    assign obi_req_o   = w_run & (r_state == ST_BUS_REQ);
    assign obi_addr_o  = w_run ? w_bus_addr : 32'h0;
    assign obi_wdata_o = w_run ? w_bus_wdata : 32'h0;
    assign obi_we_o    = w_run & (r_cmd != READ);
    assign obi_be_o    = w_run ? 4'hF : 4'h0;
    assign busy_o      = w_run & (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_dbg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_dbg_ctrl
// Scoreboard bench: stimulus pushes expected TX bytes and OBI transactions,
// monitors pop and compare when the DUT presents them. A randomized OBI
// slave with error injection backs the bus.
// -----------------------------------------------------------------------------
module tb_uart_dbg_ctrl;

    localparam logic [31:0] BOOT  = 32'h0300_0004;
    localparam logic [31:0] FETCH = 32'h0300_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        obi_req;
    logic        obi_gnt = 1'b0;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        obi_rvalid = 1'b0;
    logic [31:0] obi_rdata = 32'h0;
    logic        obi_err = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    uart_dbg_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr),
        .obi_we_o(obi_we), .obi_be_o(obi_be), .obi_wdata_o(obi_wdata),
        .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata), .obi_err_i(obi_err),
        .busy_o(busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_op_t;

    logic [7:0]  exp_tx_q[$];
    bus_op_t     exp_bus_q[$];
    logic [7:0]  frame[$];
    logic [31:0] slave_mem[logic [31:0]];
    logic [31:0] model_mem[logic [31:0]];
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    int          n_pass = 0;
    int          n_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: got %h, nothing expected (t=%0t)", name, act, $time);
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : dflt(a);
    endfunction

    task automatic exp_tx(input logic [7:0] b);
        exp_tx_q.push_back(b);
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_op_t op;
        op.we = we; op.addr = a; op.wdata = d;
        exp_bus_q.push_back(op);
    endtask

    // ---------------- OBI slave + TX back-pressure ----------------
    logic        s_pend = 1'b0;
    int          s_dly = 0;
    logic [31:0] s_rdata = 32'h0;
    logic        s_err = 1'b0;

    always @(posedge clk) begin
        logic [31:0] a;
        #2;
        obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_err = 1'b0; obi_rdata = 32'h0;
        tx_ready = ($urandom_range(0, 3) != 0);
        if (rst) begin
            s_pend = 1'b0;
        end else begin
            if (s_pend) begin
                if (s_dly == 0) begin
                    obi_rvalid = 1'b1; obi_rdata = s_rdata; obi_err = s_err; s_pend = 1'b0;
                end else s_dly--;
            end
            if (obi_req && !s_pend && !obi_rvalid && $urandom_range(0, 2) != 0) begin
                obi_gnt = 1'b1;
                a = obi_addr;
                s_err = err_en && (a == err_addr);
                if (obi_we) begin
                    if (!s_err) slave_mem[a] = obi_wdata;
                    s_rdata = 32'h0;
                end else begin
                    s_rdata = slave_mem.exists(a) ? slave_mem[a] : dflt(a);
                end
                s_pend = 1'b1;
                s_dly  = $urandom_range(0, 2);
            end
        end
    end

    // ---------------- monitors ----------------
    logic        h_wait = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;

    always @(negedge clk) begin
        bus_op_t op;
        logic [7:0] eb;
        if (tx_valid && tx_ready) begin
            if (exp_tx_q.size() == 0) fail_now("tx_extra", {24'h0, tx_data});
            else begin
                eb = exp_tx_q.pop_front();
                check("tx_byte", {24'h0, tx_data}, {24'h0, eb});
            end
        end
        if (!rst && h_wait)
            check("req_hold", {29'h0, obi_req, obi_addr == h_addr,
                               (obi_we == h_we) && (obi_wdata == h_wdata)}, 32'h7);
        if (obi_req && obi_gnt) begin
            if (exp_bus_q.size() == 0) fail_now("bus_extra", obi_addr);
            else begin
                op = exp_bus_q.pop_front();
                check("bus_we",   {31'h0, obi_we}, {31'h0, op.we});
                check("bus_addr", obi_addr, op.addr);
                check("bus_be",   {28'h0, obi_be}, 32'hF);
                if (op.we) check("bus_wdata", obi_wdata, op.wdata);
            end
        end
        h_wait  = !rst && obi_req && !obi_gnt;
        h_addr  = obi_addr; h_we = obi_we; h_wdata = obi_wdata;
    end

    // ---------------- drivers ----------------
    task automatic send_frame();
        int n;
        while (frame.size() > 0) begin
            rx_data  = frame.pop_front();
            rx_valid = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (rx_ready) break;
                n++;
                if (n > 2000) begin
                    fail_now("rx_stall_timeout", {24'h0, rx_data});
                    break;
                end
            end
            @(posedge clk); #1;
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy || exp_tx_q.size() != 0 || exp_bus_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin
                fail_now("idle_timeout", {16'h0, 8'(exp_tx_q.size()), 8'(exp_bus_q.size())});
                exp_tx_q.delete(); exp_bus_q.delete();
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_checks();
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_req",      {31'h0, obi_req},  32'h0);
        check("rst_busy",     {31'h0, busy},     32'h0);
        check("rst_be",       {28'h0, obi_be},   32'h0);
    endtask

    task automatic read_deadbeef();
        exp_tx(8'h06); exp_tx(8'hEF); exp_tx(8'hBE); exp_tx(8'hAD); exp_tx(8'hDE); exp_tx(8'h04);
        exp_bus(1'b0, 32'h1000_0000, 32'h0);
        frame = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00};
        send_frame(); wait_idle();
    endtask

    // Reference model: computes replies and bus traffic from the command rules.
    task automatic run_random(input int kind, input logic [31:0] base, input logic [7:0] n);
        logic [31:0] a, d;
        logic        errd;
        a = {base[31:2], 2'b00};
        errd = 1'b0;
        frame.delete();
        frame.push_back(kind == 0 ? 8'h11 : (kind == 1 ? 8'h12 : 8'h13));
        for (int j = 0; j < 4; j++) frame.push_back(base[8*j +: 8]);
        if (kind == 2) begin
            exp_bus(1'b1, BOOT, a);
            if (err_en && err_addr == BOOT) exp_tx(8'h15);
            else begin
                exp_bus(1'b1, FETCH, 32'h1);
                exp_tx((err_en && err_addr == FETCH) ? 8'h15 : 8'h06);
            end
        end else if (kind == 0) begin
            frame.push_back(n);
            exp_tx(8'h06);
            for (int i = 0; i <= int'(n) && !errd; i++) begin
                exp_bus(1'b0, a, 32'h0);
                if (err_en && a == err_addr) begin
                    exp_tx(8'h15); errd = 1'b1;
                end else begin
                    d = mrd(a);
                    for (int j = 0; j < 4; j++) exp_tx(d[8*j +: 8]);
                    a = a + 32'd4;
                end
            end
            if (!errd) exp_tx(8'h04);
        end else begin
            frame.push_back(n);
            for (int i = 0; i <= int'(n); i++) begin
                d = $urandom;
                for (int j = 0; j < 4; j++) frame.push_back(d[8*j +: 8]);
                if (!errd) begin
                    exp_bus(1'b1, a, d);
                    if (err_en && a == err_addr) errd = 1'b1;
                    else model_mem[a] = d;
                end
                a = a + 32'd4;
            end
            exp_tx(errd ? 8'h15 : 8'h06);
        end
        send_frame();
        wait_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          kind;
        logic [31:0] base;
        logic [7:0]  n;

        repeat (3) @(posedge clk);
        @(negedge clk); reset_checks();
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst", {31'h0, rx_ready}, 32'h1);
        check("busy_after_rst",     {31'h0, busy},     32'h0);
        @(posedge clk); #1;

        // READ one word
        slave_mem[32'h1000_0000] = 32'hDEAD_BEEF;
        read_deadbeef();

        // WRITE two words
        exp_bus(1'b1, 32'h1000_0004, 32'h4433_2211);
        exp_bus(1'b1, 32'h1000_0008, 32'h8877_6655);
        exp_tx(8'h06);
        frame = '{8'h12, 8'h04, 8'h00, 8'h00, 8'h10, 8'h01,
                  8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(); wait_idle();

        // EXEC
        exp_bus(1'b1, BOOT, 32'h1000_0080);
        exp_bus(1'b1, FETCH, 32'h1);
        exp_tx(8'h06);
        frame = '{8'h13, 8'h80, 8'h00, 8'h00, 8'h10};
        send_frame(); wait_idle();

        // READ n=1 with error on first word
        err_en = 1'b1; err_addr = 32'h1000_0000;
        exp_tx(8'h06); exp_tx(8'h15);
        exp_bus(1'b0, 32'h1000_0000, 32'h0);
        frame = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01};
        send_frame(); wait_idle();
        err_en = 1'b0;
        repeat (20) @(posedge clk); #1;

        // Stray bytes then READ
        frame = '{8'h00, 8'hFF};
        send_frame();
        repeat (10) @(posedge clk); #1;
        read_deadbeef();

        // Reset mid-WRITE after two data bytes, then READ
        frame = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'hAA, 8'hBB};
        send_frame();
        @(negedge clk); check("busy_mid_write", {31'h0, busy}, 32'h1);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); reset_checks();
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst2", {31'h0, rx_ready}, 32'h1);
        repeat (10) @(posedge clk); #1;
        read_deadbeef();

        // Randomized commands against the reference model
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 2);
            base = 32'h2000_0000 + {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
            if (t == 7) base = 32'hFFFF_FFF9;
            n = 8'($urandom_range(0, 3));
            err_en = ($urandom_range(0, 3) == 0);
            if (kind == 2) err_addr = $urandom_range(0, 1) ? BOOT : FETCH;
            else err_addr = {base[31:2], 2'b00} + 32'($urandom_range(0, int'(n))) * 32'd4;
            if ($urandom_range(0, 3) == 0) begin
                frame = '{8'($urandom_range(8'h14, 8'hFF))};
                send_frame();
            end
            run_random(kind, base, n);
            err_en = 1'b0;
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
